// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 64x32 data memory between the MEM
// stage of the CPU and a host (loader/debug) port. The CPU has priority,
// but a host request refused for STARVE_LIMIT consecutive cycles wins for
// exactly one cycle and the CPU stalls in that cycle.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [5:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        host_valid,
  input  logic        host_we,
  input  logic [5:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ready,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic        mem_we,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [15:0] host_xfer_cnt,
  output logic [15:0] stall_cnt
);

  // The starvation counter is 4 bits wide, which bounds the legal limit.
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       host_grant;

  // Grant decision and memory port steering; reset forces the port idle.
  always_comb begin
    host_grant = host_valid && !reset && (!cpu_req || (starve_cnt == LIMIT));
    host_ready = host_grant;
    cpu_stall  = cpu_req && host_grant;
    cpu_rdata  = mem_rdata;
    if (host_grant) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_req && cpu_we && !reset;
    end
  end

  // Count consecutive refused host cycles; any grant or idle host clears it,
  // so a forced grant is followed by CPU priority again.
  always_ff @(posedge clk) begin
    if (reset || host_grant || !host_valid) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Capture the asynchronous read data of a granted host read; the response
  // is valid for exactly the following cycle and the data is held afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_rvalid <= 1'b0;
      host_rdata  <= 32'd0;
    end else if (host_grant && !host_we) begin
      host_rvalid <= 1'b1;
      host_rdata  <= mem_rdata;
    end else begin
      host_rvalid <= 1'b0;
    end
  end

  // Free-running statistics counters; both wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_xfer_cnt <= 16'd0;
      stall_cnt     <= 16'd0;
    end else begin
      if (host_grant) begin
        host_xfer_cnt <= host_xfer_cnt + 16'd1;
      end
      if (cpu_stall) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule
